// File: rtl/crank_cam_emulator.sv
// Crank/cam wheel signal source: emits a missing-tooth crank signal (vr) and a
// once-per-720-degree cam signal, paced by a runtime prescaler.
module crank_cam_emulator #(
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int SUB           = 64,
    parameter int PRESC_W       = 16,
    parameter int CAM_ON_TOOTH  = 4,
    parameter int CAM_OFF_TOOTH = 54
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [PRESC_W-1:0]             presc_top,
    output logic                           vr,
    output logic                           cam,
    output logic                           cam_phase,
    output logic [$clog2(TEETH_TOTAL)-1:0] tooth_num,
    output logic                           rev_strobe
);

    localparam int TOOTH_W  = $clog2(TEETH_TOTAL);
    localparam int GAP_SUBS = (TEETH_MISSING + 1) * SUB;
    localparam int SUB_W    = $clog2(GAP_SUBS);

    localparam logic [TOOTH_W-1:0] LAST      = TOOTH_W'(TEETH_TOTAL - TEETH_MISSING - 1);
    localparam logic [TOOTH_W-1:0] CAM_ON_T  = TOOTH_W'(CAM_ON_TOOTH);
    localparam logic [TOOTH_W-1:0] CAM_OFF_T = TOOTH_W'(CAM_OFF_TOOTH);
    localparam logic [SUB_W-1:0]   TOP_NORM  = SUB_W'(SUB - 1);
    localparam logic [SUB_W-1:0]   TOP_GAP   = SUB_W'(GAP_SUBS - 1);

    logic [PRESC_W-1:0] pcnt;
    logic [PRESC_W-1:0] presc_act;
    logic [SUB_W-1:0]   sub;

    logic               stb;
    logic               wrap;
    logic [SUB_W-1:0]   sub_top;
    logic [SUB_W-1:0]   half;
    logic [TOOTH_W-1:0] tooth_nxt;
    logic               phase_nxt;
    logic               cam_nxt;

    // Next-tooth values are only committed when the current tooth ends.
    always_comb begin
        stb       = (pcnt == presc_act);
        wrap      = (tooth_num == LAST);
        sub_top   = wrap ? TOP_GAP : TOP_NORM;
        half      = sub_top >> 1;
        tooth_nxt = wrap ? '0 : tooth_num + 1'b1;
        phase_nxt = wrap ? ~cam_phase : cam_phase;
        cam_nxt   = cam;
        if (phase_nxt) begin
            if (tooth_nxt == CAM_ON_T)
                cam_nxt = 1'b1;
            // Checked second so deassert wins when both teeth coincide.
            if (tooth_nxt == CAM_OFF_T)
                cam_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt       <= '0;
            presc_act  <= presc_top;
            sub        <= '0;
            tooth_num  <= '0;
            vr         <= 1'b0;
            cam        <= 1'b0;
            cam_phase  <= 1'b0;
            rev_strobe <= 1'b0;
        end else if (en) begin
            rev_strobe <= 1'b0;
            if (stb) begin
                pcnt <= '0;
                if (sub == sub_top) begin
                    sub       <= '0;
                    vr        <= 1'b0;
                    tooth_num <= tooth_nxt;
                    cam_phase <= phase_nxt;
                    cam       <= cam_nxt;
                    // Speed changes only take effect on a revolution boundary.
                    if (wrap) begin
                        rev_strobe <= 1'b1;
                        presc_act  <= presc_top;
                    end
                end else begin
                    if (sub == half)
                        vr <= 1'b1;
                    sub <= sub + 1'b1;
                end
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end else begin
            rev_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crank_cam_emulator.sv
// Scoreboard bench for crank_cam_emulator: expected edge times of every output
// are queued per scenario and popped as the DUT outputs toggle.
module tb_crank_cam_emulator;

    localparam int SUBN    = 64;
    localparam int LASTT   = 57;
    localparam int REV     = 60 * SUBN;
    localparam int CAM_ON  = 4;
    localparam int CAM_OFF = 54;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] presc_top;
    logic        vr;
    logic        cam;
    logic        cam_phase;
    logic [5:0]  tooth_num;
    logic        rev_strobe;

    crank_cam_emulator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .presc_top (presc_top),
        .vr        (vr),
        .cam       (cam),
        .cam_phase (cam_phase),
        .tooth_num (tooth_num),
        .rev_strobe(rev_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit v;
    } ev_t;

    ev_t q_vr[$];
    ev_t q_cam[$];
    ev_t q_ph[$];
    ev_t q_rs[$];

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  r0 = 0;
    int  p_j = 32'h4000_0000;
    int  p_len = 0;
    bit  mon_on = 1'b0;
    bit  p_vr, p_cam, p_ph, p_rs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue one expected edge at local subtick j of a revolution starting at base.
    task automatic add_ev(input int sig, input int base, input int s, input int j,
                          input bit v, input int jmax, input int extra);
        ev_t e;
        if (j <= jmax) begin
            e.t = base + s * j + ((j > p_j) ? p_len : 0) + extra;
            e.v = v;
            case (sig)
                0: q_vr.push_back(e);
                1: q_cam.push_back(e);
                2: q_ph.push_back(e);
                default: q_rs.push_back(e);
            endcase
        end
    endtask

    task automatic push_rev(input int base, input int s, input int jmax, input bit ph);
        for (int k = 0; k < LASTT; k++) begin
            add_ev(0, base, s, k * SUBN + SUBN / 2, 1'b1, jmax, 0);
            add_ev(0, base, s, (k + 1) * SUBN, 1'b0, jmax, 0);
        end
        add_ev(0, base, s, LASTT * SUBN + 3 * SUBN / 2, 1'b1, jmax, 0);
        add_ev(0, base, s, REV, 1'b0, jmax, 0);
        if (ph) begin
            add_ev(1, base, s, CAM_ON * SUBN, 1'b1, jmax, 0);
            add_ev(1, base, s, CAM_OFF * SUBN, 1'b0, jmax, 0);
        end
        add_ev(2, base, s, REV, !ph, jmax, 0);
        add_ev(3, base, s, REV, 1'b1, jmax, 0);
        add_ev(3, base, s, REV, 1'b0, jmax, 1);
    endtask

    task automatic observe(input int sig, input bit v);
        string nm;
        ev_t   e;
        int    n;
        case (sig)
            0: begin nm = "vr";         n = q_vr.size();  if (n > 0) e = q_vr.pop_front();  end
            1: begin nm = "cam";        n = q_cam.size(); if (n > 0) e = q_cam.pop_front(); end
            2: begin nm = "cam_phase";  n = q_ph.size();  if (n > 0) e = q_ph.pop_front();  end
            default: begin nm = "rev_strobe"; n = q_rs.size(); if (n > 0) e = q_rs.pop_front(); end
        endcase
        if (n == 0) begin
            chk({nm, "_unexpected_edge"}, n, 1);
        end else begin
            chk({nm, "_edge_cycle"}, cyc, e.t);
            chk({nm, "_edge_value"}, v, e.v);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (vr !== p_vr)             begin observe(0, vr);         p_vr = vr;         end
            if (cam !== p_cam)           begin observe(1, cam);        p_cam = cam;       end
            if (cam_phase !== p_ph)      begin observe(2, cam_phase);  p_ph = cam_phase;  end
            if (rev_strobe !== p_rs)     begin observe(3, rev_strobe); p_rs = rev_strobe; end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_vr"}, vr, 0);
        chk({pfx, "_cam"}, cam, 0);
        chk({pfx, "_cam_phase"}, cam_phase, 0);
        chk({pfx, "_tooth"}, tooth_num, 0);
        chk({pfx, "_rev_strobe"}, rev_strobe, 0);
    endtask

    task automatic arm();
        rst    = 1'b1;
        r0     = cyc;
        p_vr   = vr;
        p_cam  = cam;
        p_ph   = cam_phase;
        p_rs   = rev_strobe;
        mon_on = 1'b1;
    endtask

    task automatic start(input logic [15:0] p);
        mon_on    = 1'b0;
        rst       = 1'b0;
        en        = 1'b1;
        presc_top = p;
        p_j       = 32'h4000_0000;
        p_len     = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        arm();
    endtask

    task automatic finish_scn(input string pfx);
        mon_on = 1'b0;
        chk({pfx, "_vr_missing"}, q_vr.size(), 0);
        chk({pfx, "_cam_missing"}, q_cam.size(), 0);
        chk({pfx, "_phase_missing"}, q_ph.size(), 0);
        chk({pfx, "_strobe_missing"}, q_rs.size(), 0);
        q_vr.delete();
        q_cam.delete();
        q_ph.delete();
        q_rs.delete();
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        presc_top = '0;

        // Full speed, four revolutions: tooth timing, gap, strobe and cam.
        start(16'd0);
        for (int r = 0; r < 4; r++)
            push_rev(r0 + r * REV, 1, REV, r[0]);
        wait_cyc(r0 + 4 * REV + 4);
        finish_scn("s1");

        // Prescaler of 3 scales every interval by 4.
        start(16'd3);
        push_rev(r0, 4, REV, 1'b0);
        wait_cyc(r0 + 4 * REV + 4);
        finish_scn("s2");

        // Speed change mid-revolution is deferred to the wrap.
        start(16'd0);
        push_rev(r0, 1, REV, 1'b0);
        push_rev(r0 + REV, 2, REV, 1'b1);
        wait_cyc(r0 + 20 * SUBN + 10);
        chk("s3_tooth_at_switch", tooth_num, 20);
        presc_top = 16'd1;
        wait_cyc(r0 + 3 * REV + 4);
        finish_scn("s3");

        // Pause 100 clocks at tooth 10, subtick 40.
        start(16'd0);
        p_j   = 10 * SUBN + 40;
        p_len = 100;
        push_rev(r0, 1, REV, 1'b0);
        wait_cyc(r0 + 10 * SUBN + 40);
        en = 1'b0;
        wait_cyc(r0 + 10 * SUBN + 90);
        chk("s4_hold_vr", vr, 1);
        chk("s4_hold_tooth", tooth_num, 10);
        chk("s4_hold_strobe", rev_strobe, 0);
        wait_cyc(r0 + 10 * SUBN + 140);
        chk("s4_hold_tooth_end", tooth_num, 10);
        chk("s4_hold_vr_end", vr, 1);
        en = 1'b1;
        wait_cyc(r0 + REV + 100 + 4);
        finish_scn("s4");

        // Reset during the gap-tooth high phase of a phase-1 revolution.
        start(16'd0);
        push_rev(r0, 1, REV, 1'b0);
        push_rev(r0 + REV, 1, REV - 40, 1'b1);
        wait_cyc(r0 + 2 * REV - 40);
        chk("s5_pre_vr", vr, 1);
        chk("s5_pre_phase", cam_phase, 1);
        chk("s5_pre_tooth", tooth_num, LASTT);
        finish_scn("s5a");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("s5_midreset");
        arm();
        push_rev(r0, 1, REV, 1'b0);
        wait_cyc(r0 + REV + 4);
        finish_scn("s5b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
